// File: rtl/seq_divider.sv
// seq_divider: sequential N-bit unsigned restoring divider with a Go/Done
// handshake. Each CALC cycle performs one shift / trial-subtract / restore
// step, so a normal division takes N cycles in CALC plus one DONE cycle.
//
// Optional feature macro: SEQ_DIVIDER_ZERO_TRAP_EN
//   defined   - a zero divisor is trapped at the accept edge: the FSM jumps
//               straight to DONE with quotient = all ones,
//               remainder = dividend and div_by_zero = 1.
//   undefined - div_by_zero is tied low. A zero divisor runs the normal
//               N iterations, which give the same quotient/remainder.
//
// Handshake (valid/ready): go acts as "valid", and the FSM is "ready" only
// in IDLE. A transfer happens on a rising edge where state == IDLE and
// go == 1. That edge also captures dividend and divisor. go is ignored in
// CALC and DONE and is not queued. done is a one-cycle Moore pulse in DONE.
// The quotient, remainder and div_by_zero registers hold their values
// until the next completion or a reset.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high reset; has priority over go
//   go           start request, sampled only in IDLE
//   dividend     N-bit unsigned dividend
//   divisor      N-bit unsigned divisor
//   quotient     registered quotient
//   remainder    registered remainder
//   busy         high while in CALC
//   done         one-cycle completion pulse (state == DONE)
//   div_by_zero  divisor was zero for the current result (trap build only)
//   dbg_state    current FSM state (IDLE=0, CALC=1, DONE=2)
module seq_divider #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         go,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state;
    logic [N:0]    a;       // partial remainder; its MSB is the sign of a trial subtract
    logic [N-1:0]  q;       // dividend shifts out of the top, quotient bits shift in
    logic [N-1:0]  m;       // captured divisor
    logic [CW-1:0] cnt;

    logic [2*N:0]  aq_sh;
    logic [N:0]    diff;
    logic [N:0]    a_next;
    logic [N-1:0]  q_next;

    // One restoring iteration. "Restore" means keeping the shifted value
    // instead of the difference, which is the same as adding M back.
    always_comb begin
        aq_sh  = {a, q} << 1;
        diff   = aq_sh[2*N:N] - {1'b0, m};
        a_next = diff[N] ? aq_sh[2*N:N] : diff;
        q_next = aq_sh[N-1:0] | {{(N-1){1'b0}}, ~diff[N]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            a         <= '0;
            q         <= '0;
            m         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SEQ_DIVIDER_ZERO_TRAP_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        a   <= '0;
                        q   <= dividend;
                        m   <= divisor;
                        cnt <= '0;
`ifdef SEQ_DIVIDER_ZERO_TRAP_EN
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    a   <= a_next;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient  <= q_next;
                        remainder <= a_next[N-1:0];
`ifdef SEQ_DIVIDER_ZERO_TRAP_EN
                        div_by_zero <= 1'b0;
`endif
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SEQ_DIVIDER_ZERO_TRAP_EN
    assign div_by_zero = 1'b0;
`endif

    assign busy      = (state == CALC);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (N = 4). All expected values are
// hand-computed constants.
module tb_seq_divider;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         go;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // clock / reset
  always #5 clock = ~clock;

  seq_divider #(.N(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .go          (go),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs are driven and outputs
  // sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one division and check latency, handshake and result.
  // elat = number of edges after the accept edge until done is seen.
  task automatic run_div(input string tag, input logic [N-1:0] dd, input logic [N-1:0] dv,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input int elat, input logic edz);
    int lat;
    dividend = dd;
    divisor  = dv;
    go       = 1'b1;
    tick();
    go = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'(elat > 1));
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
    tick();
    check({tag, "_done_drop"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(dbg_state), 0);
  endtask

  initial begin : stimulus
    int pulses;
    int gap;
    logic [N-1:0] snap_q;
    logic [N-1:0] snap_r;
    logic         zero_dbz;
    int           zero_lat;

    reset    = 1'b1;
    go       = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_quotient", 32'(quotient), 0);
    check("rst_remainder", 32'(remainder), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    check("rst_state", 32'(dbg_state), 0);
    tick();

    // 13 / 4 = 3 rem 1, then outputs hold
    run_div("d13_4", 4'd13, 4'd4, 4'd3, 4'd1, N, 1'b0);
    tick();
    tick();
    check("hold_quotient", 32'(quotient), 3);
    check("hold_remainder", 32'(remainder), 1);

    run_div("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, N, 1'b0);
    tick();
    run_div("d7_9", 4'd7, 4'd9, 4'd0, 4'd7, N, 1'b0);
    tick();
    run_div("d0_5", 4'd0, 4'd5, 4'd0, 4'd0, N, 1'b0);
    tick();

    // divide by zero
`ifdef SEQ_DIVIDER_ZERO_TRAP_EN
    zero_lat = 0;
    zero_dbz = 1'b1;
`else
    zero_lat = N;
    zero_dbz = 1'b0;
`endif
    run_div("d9_0", 4'd9, 4'd0, 4'd15, 4'd9, zero_lat, zero_dbz);
    tick();
    // a nonzero divisor afterwards clears the zero flag
    run_div("d10_3", 4'd10, 4'd3, 4'd3, 4'd1, N, 1'b0);
    tick();

    // go and operand changes during CALC are ignored
    dividend = 4'd13;
    divisor  = 4'd4;
    go       = 1'b1;
    tick();
    go = 1'b0;
    tick();
    go       = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd2;
    tick();
    go       = 1'b0;
    dividend = 4'd9;
    divisor  = 4'd1;
    pulses = 0;
    snap_q = '0;
    snap_r = '0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        pulses++;
        snap_q = quotient;
        snap_r = remainder;
      end
      tick();
    end
    check("ign_pulses", pulses, 1);
    check("ign_quotient", 32'(snap_q), 3);
    check("ign_remainder", 32'(snap_r), 1);

    // reset mid-operation
    dividend = 4'd14;
    divisor  = 4'd3;
    go       = 1'b1;
    tick();
    go = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_quotient", 32'(quotient), 0);
    check("mrst_remainder", 32'(remainder), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_state", 32'(dbg_state), 0);
    pulses = 0;
    for (int i = 0; i < N + 2; i++) begin
      if (done) pulses++;
      tick();
    end
    check("mrst_no_done", pulses, 0);
    run_div("d14_3", 4'd14, 4'd3, 4'd4, 4'd2, N, 1'b0);
    tick();

    // go held high: one result every N+2 edges
    dividend = 4'd11;
    divisor  = 4'd2;
    go       = 1'b1;
    tick();
    gap = 0;
    while (!done && gap < 20) begin
      tick();
      gap++;
    end
    check("b2b_first_latency", gap, N);
    check("b2b_quotient0", 32'(quotient), 5);
    check("b2b_remainder0", 32'(remainder), 1);
    for (int k = 1; k <= 2; k++) begin
      gap = 0;
      tick();
      gap++;
      while (!done && gap < 20) begin
        tick();
        gap++;
      end
      check($sformatf("b2b_period%0d", k), gap, N + 2);
      check($sformatf("b2b_quotient%0d", k), 32'(quotient), 5);
      check($sformatf("b2b_remainder%0d", k), 32'(remainder), 1);
    end
    go = 1'b0;
    tick();
    tick();
    check("b2b_stop_idle", 32'(dbg_state), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
